// File: rtl/tiny_nn_fp_acc_pkg.sv
// Shared float-format definitions for the tiny-nn datapath: class enum, default
// 8/7 constants and width-generic helpers for bias, StdNaN, Inf and classification.
package tiny_nn_fp_acc_pkg;

    typedef enum logic [1:0] {
        FPClassZero,
        FPClassNorm,
        FPClassInf,
        FPClassNaN
    } fp_class_e;

    typedef struct packed {
        logic       sgn;
        logic [7:0] exp;
        logic [6:0] mant;
    } fp_t;

    localparam fp_t FpZero   = '{sgn: 1'b0, exp: 8'h00, mant: 7'h00};
    localparam fp_t FpOne    = '{sgn: 1'b0, exp: 8'h7f, mant: 7'h00};
    localparam fp_t FpPosInf = '{sgn: 1'b0, exp: 8'hff, mant: 7'h00};
    localparam fp_t FpNegInf = '{sgn: 1'b1, exp: 8'hff, mant: 7'h00};
    localparam fp_t FpStdNaN = '{sgn: 1'b1, exp: 8'hff, mant: 7'h7f};

    function automatic int fp_bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    function automatic logic [63:0] fp_field_mask(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic logic [63:0] fp_std_nan(input int exp_width, input int mant_width);
        return fp_field_mask(1 + exp_width + mant_width);
    endfunction

    function automatic logic [63:0] fp_inf(input logic sgn, input int exp_width,
                                           input int mant_width);
        return ({63'd0, sgn} << (exp_width + mant_width))
             | (fp_field_mask(exp_width) << mant_width);
    endfunction

    // A negative zero word is NaN in this format; only the all-zero word is zero.
    function automatic fp_class_e fp_classify(input logic [63:0] word, input int exp_width,
                                              input int mant_width);
        logic [63:0] mant;
        logic [63:0] expo;
        logic [63:0] sgn;
        mant = word & fp_field_mask(mant_width);
        expo = (word >> mant_width) & fp_field_mask(exp_width);
        sgn  = (word >> (exp_width + mant_width)) & 64'd1;
        if (expo == 64'd0) begin
            return (mant != 64'd0 || sgn != 64'd0) ? FPClassNaN : FPClassZero;
        end
        if (expo == fp_field_mask(exp_width)) begin
            return (mant != 64'd0) ? FPClassNaN : FPClassInf;
        end
        return FPClassNorm;
    endfunction

endpackage

// File: rtl/tiny_nn_fp_norm.sv
// Combinational leading-one detector and left shifter; returns the shift that
// brings the leading one to the MSB and the stored bits below it.
module tiny_nn_fp_norm #(
    parameter int Width      = 8,
    parameter int ShiftWidth = $clog2(Width)
) (
    input  logic [Width-1:0]      value,
    output logic [ShiftWidth-1:0] shift,
    output logic [Width-2:0]      mant
);

    always_comb begin
        shift = '0;
        for (int i = 0; i < Width; i++) begin
            if (value[i]) begin
                shift = ShiftWidth'(Width - 1 - i);
            end
        end
        mant = (Width - 1)'(value << shift);
    end

endmodule

// File: rtl/tiny_nn_fp_acc.sv
// Multi-cycle floating-point accumulator: ACCEPT -> ALIGN -> NORM per operand,
// OUT presents one result per group terminated by last.
module tiny_nn_fp_acc
    import tiny_nn_fp_acc_pkg::*;
#(
    parameter int  ExpWidth   = 8,
    parameter int  MantWidth  = 7,
    parameter int  CountWidth = 8,
    localparam int FPWidth    = 1 + ExpWidth + MantWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [FPWidth-1:0]    in_data_i,
    input  logic                  in_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [FPWidth-1:0]    out_data_o,
    output logic [CountWidth-1:0] out_count_o,
    output logic                  out_ovf_o
);

    localparam int ShiftWidth = $clog2(MantWidth + 1);
    localparam logic [FPWidth-1:0] StdNan = FPWidth'(fp_std_nan(ExpWidth, MantWidth));
    localparam logic [FPWidth-1:0] PosInf = FPWidth'(fp_inf(1'b0, ExpWidth, MantWidth));
    localparam logic [FPWidth-1:0] NegInf = FPWidth'(fp_inf(1'b1, ExpWidth, MantWidth));

    typedef enum logic [1:0] {StAccept, StAlign, StNorm, StOut} state_e;

    state_e                state_reg;
    logic [FPWidth-1:0]    op_reg, acc_reg, special_val_reg;
    logic                  last_reg, special_reg, sgn_reg, sub_reg;
    logic                  ovf_reg, in_ready_reg, out_valid_reg;
    logic [ExpWidth-1:0]   exp_reg;
    logic [MantWidth:0]    big_reg, small_reg;
    logic [CountWidth-1:0] count_reg;

    fp_class_e             acc_class, op_class;
    logic                  op_is_big;
    logic [FPWidth-1:0]    big_word, small_word;
    logic [ExpWidth-1:0]   exp_diff;
    logic [MantWidth:0]    small_aligned;
    logic                  special_next;
    logic [FPWidth-1:0]    special_val_next;

    // ALIGN: order by magnitude, align the smaller one, resolve special operands.
    always_comb begin
        acc_class     = fp_classify(64'(acc_reg), ExpWidth, MantWidth);
        op_class      = fp_classify(64'(op_reg), ExpWidth, MantWidth);
        op_is_big     = op_reg[FPWidth-2:0] > acc_reg[FPWidth-2:0];
        big_word      = op_is_big ? op_reg : acc_reg;
        small_word    = op_is_big ? acc_reg : op_reg;
        exp_diff      = big_word[FPWidth-2 -: ExpWidth] - small_word[FPWidth-2 -: ExpWidth];
        small_aligned = {1'b1, small_word[MantWidth-1:0]} >> exp_diff;
        if (32'(exp_diff) > MantWidth) begin
            small_aligned = '0;
        end

        special_next     = 1'b1;
        special_val_next = StdNan;
        if (acc_class == FPClassNaN || op_class == FPClassNaN) begin
            special_val_next = StdNan;
        end else if (acc_class == FPClassInf && op_class == FPClassInf
                     && acc_reg[FPWidth-1] != op_reg[FPWidth-1]) begin
            special_val_next = StdNan;
        end else if (acc_class == FPClassInf || op_class == FPClassZero) begin
            special_val_next = acc_reg;
        end else if (op_class == FPClassInf || acc_class == FPClassZero) begin
            special_val_next = op_reg;
        end else begin
            special_next = 1'b0;
        end
    end

    logic [MantWidth+1:0]  sum;
    logic [ShiftWidth-1:0] lz_shift;
    logic [MantWidth-1:0]  lz_mant;
    logic [ExpWidth-1:0]   exp_plus;
    logic [FPWidth-1:0]    result_next;
    logic                  ovf_next;

    assign sum = sub_reg ? ({1'b0, big_reg} - {1'b0, small_reg})
                         : ({1'b0, big_reg} + {1'b0, small_reg});

    tiny_nn_fp_norm #(
        .Width      (MantWidth + 1),
        .ShiftWidth (ShiftWidth)
    ) u_norm (
        .value (sum[MantWidth:0]),
        .shift (lz_shift),
        .mant  (lz_mant)
    );

    // NORM: cancellation and underflow both land on +0 since -0 would read as NaN.
    always_comb begin
        exp_plus    = exp_reg + ExpWidth'(1);
        result_next = '0;
        ovf_next    = 1'b0;
        if (special_reg) begin
            result_next = special_val_reg;
        end else if (sum[MantWidth+1]) begin
            if (exp_plus == '1) begin
                result_next = sgn_reg ? NegInf : PosInf;
                ovf_next    = 1'b1;
            end else begin
                result_next = {sgn_reg, exp_plus, sum[MantWidth:1]};
            end
        end else if (sum == '0 || 32'(lz_shift) >= 32'(exp_reg)) begin
            result_next = '0;
        end else begin
            result_next = {sgn_reg, exp_reg - ExpWidth'(lz_shift), lz_mant};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg       <= StAccept;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            acc_reg         <= '0;
            count_reg       <= '0;
            ovf_reg         <= 1'b0;
            op_reg          <= '0;
            last_reg        <= 1'b0;
            special_reg     <= 1'b0;
            special_val_reg <= '0;
            sgn_reg         <= 1'b0;
            sub_reg         <= 1'b0;
            exp_reg         <= '0;
            big_reg         <= '0;
            small_reg       <= '0;
        end else begin
            case (state_reg)
                StAccept: begin
                    if (in_valid_i) begin
                        op_reg       <= in_data_i;
                        last_reg     <= in_last_i;
                        in_ready_reg <= 1'b0;
                        state_reg    <= StAlign;
                    end
                end
                StAlign: begin
                    special_reg     <= special_next;
                    special_val_reg <= special_val_next;
                    sgn_reg         <= big_word[FPWidth-1];
                    sub_reg         <= big_word[FPWidth-1] ^ small_word[FPWidth-1];
                    exp_reg         <= big_word[FPWidth-2 -: ExpWidth];
                    big_reg         <= {1'b1, big_word[MantWidth-1:0]};
                    small_reg       <= small_aligned;
                    state_reg       <= StNorm;
                end
                StNorm: begin
                    acc_reg <= result_next;
                    ovf_reg <= ovf_reg | ovf_next;
                    if (count_reg != '1) begin
                        count_reg <= count_reg + CountWidth'(1);
                    end
                    if (last_reg) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= StOut;
                    end else begin
                        in_ready_reg <= 1'b1;
                        state_reg    <= StAccept;
                    end
                end
                StOut: begin
                    if (out_ready_i) begin
                        acc_reg       <= '0;
                        count_reg     <= '0;
                        ovf_reg       <= 1'b0;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= StAccept;
                    end
                end
                default: state_reg <= StAccept;
            endcase
        end
    end

    assign in_ready_o  = in_ready_reg;
    assign out_valid_o = out_valid_reg;
    assign out_data_o  = acc_reg;
    assign out_count_o = count_reg;
    assign out_ovf_o   = ovf_reg;

endmodule

// File: tb/tb_tiny_nn_fp_acc.sv
// Self-checking bench for tiny_nn_fp_acc: directed cases plus random groups
// checked against an integer-arithmetic reference of the float rules.
module tb_tiny_nn_fp_acc;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_data_i;
    logic        in_last_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_data_o;
    logic [7:0]  out_count_o;
    logic        out_ovf_o;

    tiny_nn_fp_acc dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_count_o (out_count_o),
        .out_ovf_o   (out_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          group_id = 0;
    logic [15:0] grp [0:299];
    int          grp_n;
    logic [15:0] last_data;
    int          last_count;
    logic        last_ovf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // 0 zero, 1 normal, 2 inf, 3 nan
    function automatic int tb_class(input logic [15:0] w);
        if (w[14:7] == 8'h00) return (w[6:0] != 7'h0 || w[15]) ? 3 : 0;
        if (w[14:7] == 8'hFF) return (w[6:0] != 7'h0) ? 3 : 2;
        return 1;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] acc, input logic [15:0] op,
                                            output logic ovf);
        int ca, co, eb, es, bs, ss, d, r, mag, e;
        logic sb, sm, sgn;
        ca  = tb_class(acc);
        co  = tb_class(op);
        ovf = 1'b0;
        if (ca == 3 || co == 3) return 16'hFFFF;
        if (ca == 2 && co == 2 && acc[15] != op[15]) return 16'hFFFF;
        if (ca == 2) return acc;
        if (co == 2) return op;
        if (co == 0) return acc;
        if (ca == 0) return op;
        if (op[14:0] > acc[14:0]) begin
            eb = int'(op[14:7]);  bs = 128 + int'(op[6:0]);  sb = op[15];
            es = int'(acc[14:7]); ss = 128 + int'(acc[6:0]); sm = acc[15];
        end else begin
            eb = int'(acc[14:7]); bs = 128 + int'(acc[6:0]); sb = acc[15];
            es = int'(op[14:7]);  ss = 128 + int'(op[6:0]);  sm = op[15];
        end
        d  = eb - es;
        ss = (d > 7) ? 0 : (ss >> d);
        r  = (sb ? -bs : bs) + (sm ? -ss : ss);
        if (r == 0) return 16'h0000;
        sgn = (r < 0);
        mag = sgn ? -r : r;
        e   = eb;
        while (mag > 255) begin mag = mag >> 1; e++; end
        while (mag < 128) begin mag = mag << 1; e--; end
        if (e >= 255) begin
            ovf = 1'b1;
            return {sgn, 8'hFF, 7'h00};
        end
        if (e <= 0) return 16'h0000;
        return {sgn, e[7:0], mag[6:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        int k;
        logic [7:0] e;
        logic [6:0] m;
        logic s;
        k = int'($urandom_range(0, 39));
        s = 1'($urandom_range(0, 1));
        m = 7'($urandom);
        case (k)
            0:       return 16'h0000;
            1:       return {1'b0, 8'h00, 7'($urandom_range(1, 127))};
            2:       return 16'h8000;
            3:       return {s, 8'hFF, 7'($urandom_range(1, 127))};
            4:       return {s, 8'hFF, 7'h00};
            5, 6, 7: e = 8'($urandom_range(248, 254));
            8, 9:    e = 8'($urandom_range(1, 6));
            default: e = 8'($urandom_range(120, 134));
        endcase
        return {s, e, m};
    endfunction

    task automatic send_op(input logic [15:0] d, input logic l);
        int waited;
        waited     = 0;
        in_data_i  = d;
        in_last_i  = l;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        while (!in_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        if (!in_ready_o) check_eq("in_ready_timeout", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic run_group(input int hold, input bit offer);
        logic [15:0] exp_data;
        logic        exp_ovf;
        logic        o;
        int          exp_cnt;
        int          lat;
        exp_data = 16'h0000;
        exp_ovf  = 1'b0;
        exp_cnt  = 0;
        for (int i = 0; i < grp_n; i++) begin
            exp_data = ref_add(exp_data, grp[i], o);
            exp_ovf  = exp_ovf | o;
            exp_cnt  = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        end
        for (int i = 0; i < grp_n; i++) send_op(grp[i], i == grp_n - 1);
        lat = 0;
        while (!out_valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd3);
        check_eq("out_data", 32'(out_data_o), 32'(exp_data));
        check_eq("out_count", 32'(out_count_o), 32'(exp_cnt));
        check_eq("out_ovf", 32'(out_ovf_o), 32'(exp_ovf));
        last_data  = out_data_o;
        last_count = int'(out_count_o);
        last_ovf   = out_ovf_o;
        if (offer) begin
            in_valid_i = 1'b1;
            in_data_i  = 16'h3F80;
            in_last_i  = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            check_eq("hold_valid", 32'(out_valid_o), 32'd1);
            check_eq("hold_data", 32'(out_data_o), 32'(exp_data));
            check_eq("hold_count", 32'(out_count_o), 32'(exp_cnt));
            check_eq("hold_in_ready", 32'(in_ready_o), 32'd0);
        end
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check_eq("valid_after_accept", 32'(out_valid_o), 32'd0);
        $display("[TB] group %0d n=%0d hold=%0d out=%04h count=%0d ovf=%0b (model %04h)",
                 group_id, grp_n, hold, last_data, last_count, last_ovf, exp_data);
        group_id++;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        check_eq({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check_eq({tag, "_out_data"}, 32'(out_data_o), 32'd0);
        check_eq({tag, "_out_count"}, 32'(out_count_o), 32'd0);
        check_eq({tag, "_out_ovf"}, 32'(out_ovf_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 16'h0000;
        in_last_i   = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_values("reset");
        rst_ni = 1'b1;

        grp[0] = 16'h3F80; grp[1] = 16'h4000; grp_n = 2;
        run_group(0, 1'b0);
        check_eq("plan_basic_data", 32'(last_data), 32'h4040);
        check_eq("plan_basic_count", 32'(last_count), 32'd2);

        grp[0] = 16'h3F80; grp[1] = 16'hBF80; grp_n = 2;
        run_group(1, 1'b0);
        check_eq("plan_cancel", 32'(last_data), 32'h0000);

        grp[0] = 16'h7F7F; grp[1] = 16'h7F7F; grp_n = 2;
        run_group(0, 1'b0);
        check_eq("plan_ovf_data", 32'(last_data), 32'h7F80);
        check_eq("plan_ovf_flag", 32'(last_ovf), 32'd1);
        grp[0] = 16'h3F80; grp_n = 1;
        run_group(0, 1'b0);
        check_eq("plan_ovf_cleared", 32'(last_ovf), 32'd0);
        check_eq("plan_single", 32'(last_data), 32'h3F80);

        grp[0] = 16'h3F80; grp[1] = 16'h0001; grp[2] = 16'h3F80; grp_n = 3;
        run_group(0, 1'b0);
        check_eq("plan_nan_sticky", 32'(last_data), 32'hFFFF);
        grp[0] = 16'h7F80; grp[1] = 16'hFF80; grp_n = 2;
        run_group(0, 1'b0);
        check_eq("plan_inf_minus_inf", 32'(last_data), 32'hFFFF);
        grp[0] = 16'h8000; grp_n = 1;
        run_group(0, 1'b0);
        check_eq("plan_neg_zero_canon", 32'(last_data), 32'hFFFF);

        grp[0] = 16'h3F80; grp[1] = 16'h3F80; grp_n = 2;
        run_group(5, 1'b1);
        check_eq("plan_bp_data", 32'(last_data), 32'h4000);
        grp[0] = 16'h4000; grp_n = 1;
        run_group(0, 1'b0);
        check_eq("plan_bp_not_consumed", 32'(last_count), 32'd1);

        send_op(16'h3F80, 1'b0);
        send_op(16'h4000, 1'b0);
        check_eq("align_in_ready", 32'(in_ready_o), 32'd0);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check_reset_values("midreset");
        rst_ni = 1'b1;
        grp[0] = 16'h4000; grp_n = 1;
        run_group(0, 1'b0);
        check_eq("plan_after_reset_data", 32'(last_data), 32'h4000);
        check_eq("plan_after_reset_count", 32'(last_count), 32'd1);

        grp_n = 260;
        for (int i = 0; i < grp_n; i++) grp[i] = {1'($urandom_range(0, 1)), 8'h7F, 7'($urandom)};
        run_group(0, 1'b0);
        check_eq("count_saturates", 32'(last_count), 32'd255);

        for (int g = 0; g < 40; g++) begin
            grp_n = int'($urandom_range(1, 6));
            for (int i = 0; i < grp_n; i++) grp[i] = rand_op();
            run_group(int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tiny_nn_fp_acc.md
# tiny_nn_fp_acc

Parametrised, multi-cycle floating-point accumulator for the tiny-nn datapath. It sums a stream of operands in the codebase's custom float format into one running total. The format is generalised to any exponent/mantissa width and uses the same NaN/Inf/zero semantics as the package classifiers. The block sits between an operand source (e.g. a multiplier output) and the result consumer, with valid/ready handshakes on both sides. Each group of operands ends with a `last` marker, which triggers one result beat.

## Interface
- `ExpWidth`, default 8: exponent width. Bias = 2^(ExpWidth-1)-1.
- `MantWidth`, default 7: stored mantissa width. Hidden leading 1 is implied.
- `CountWidth`, default 8: width of the operand counter.
- `FPWidth`, derived as 1+ExpWidth+MantWidth. Not overridable.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: synchronous active-low reset. One clock; reset is synchronous and active-low.
- `in_valid_i`, in, 1: operand valid.
- `in_ready_o`, out, 1: operand accept.
- `in_data_i`, in, FPWidth: operand, packed {sgn, exp, mant}.
- `in_last_i`, in, 1: operand is the final one of its group.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: result accept.
- `out_data_o`, out, FPWidth: accumulated result.
- `out_count_o`, out, CountWidth: number of operands in the group. Saturates at all-ones.
- `out_ovf_o`, out, 1: sticky flag; an overflow to ±Inf occurred within the group.

## Operation
- Classification, applied to every operand and result:
  - NaN if exp==0 with mant!=0; exp==0 with sgn=1; or exp==all-ones with mant!=0.
  - Inf if exp==all-ones with mant==0.
  - Zero only as the all-zero word.
  - No denormals.
- FSM states and transitions:
  - ACCEPT: `in_ready_o`=1. A handshake captures the operand and `last`, then goes to ALIGN.
  - ALIGN: compare magnitudes as {exp,mant}. Right-shift the smaller operand's hidden-bit mantissa by the exponent difference. Shifted-out bits are discarded (truncate). A difference greater than MantWidth contributes 0. Next state NORM.
  - NORM: add or subtract on MantWidth+2 bits, normalise, write the accumulator, increment the count. Next state is OUT if `last`, else ACCEPT.
  - OUT: `out_valid_o`=1, outputs driven from registers. On `out_ready_i`, clear accumulator, count and ovf, then go to ACCEPT.
- Special-value rules, in priority order:
  1. Accumulator already NaN, or operand NaN → result is StdNaN (sgn 1, exp all-ones, mant all-ones). NaN is sticky for the group.
  2. +Inf plus −Inf → StdNaN.
  3. Inf plus anything else → that Inf.
  4. Operand zero → accumulator unchanged, but the count still increments.
- Normalisation:
  - Carry out: shift right 1, exp+1.
  - Otherwise: left-shift to the leading one, decrementing exp by the shift amount.
  - Zero mantissa → +0. Exact cancellation always gives +0, never −0, because −0 is NaN in this format.
  - Exponent reaching all-ones → ±Inf and set ovf.
  - Exponent at or below 0 → flush to +0.
- The accumulator starts each group at +0.

## Timing
- Reset values:
  - state ACCEPT
  - `in_ready_o`=1
  - `out_valid_o`=0
  - `out_data_o`=0
  - `out_count_o`=0
  - `out_ovf_o`=0
  - accumulator +0
- Throughput: one operand per 3 cycles (ACCEPT, ALIGN, NORM).
- Latency: the result is valid 3 cycles after the `last` handshake, counting the handshake as cycle 0 (handshake → ALIGN → NORM → OUT).
- `in_ready_o` is 0 in ALIGN, NORM and OUT. Input data is ignored unless valid and ready are both high.
- Output is AXI-style: while `out_valid_o`=1 and `out_ready_i`=0, all out_* signals hold stable. Valid never drops without a handshake.
- A single-operand group (`last` on the first beat) returns the operand itself, with NaNs canonicalised to StdNaN.
- The count saturates and never wraps.
- Reset asserted in any state takes effect on the next edge. Any in-flight group is discarded.

## Structure
- Package additions:
  - `fp_class_e` enum: FPClassZero, FPClassNorm, FPClassInf, FPClassNaN.
  - Width-generic bias and StdNaN/Inf construction helpers, taking ExpWidth/MantWidth as function parameters.
- The existing 8/7 `fp_t` constants stay as they are for the default instance.
- One sub-module: `tiny_nn_fp_norm`. It is a combinational, parametrised leading-one detector and shifter that returns the shift amount and the normalised mantissa. It is used in NORM.

## Test plan
- Basic sum, default widths: 0x3F80 (1.0) then 0x4000 (2.0, last) → out 0x4040, count 2, ovf 0, result 3 cycles after the last handshake.
- Exact cancellation: 0x3F80 then 0xBF80 (last) → out 0x0000; never 0x8000.
- Overflow: 0x7F7F then 0x7F7F (last) → out 0x7F80, ovf 1. The next group's ovf is back to 0.
- NaN inputs: 0x3F80, 0x0001 (NaN), 0x3F80 (last) → out 0xFFFF. Also 0x7F80 then 0xFF80 (last) → 0xFFFF.
- Backpressure: `out_ready_i` held 0 for 5 cycles → `out_valid_o` stays 1, out_data stable, `in_ready_o` stays 0. Operands offered during this time are not consumed.
- Reset mid-group: assert `rst_ni`=0 during ALIGN → all outputs at reset values next cycle. A fresh group 0x4000 (last) then yields 0x4000, count 1.
